// File: rtl/mtm_alu_pkg.sv
// Shared constants for the MTM ALU serial frame receiver.
// Holds opcode values, FSM state encoding, frame-type values, error-frame
// bit positions and two small helpers (opcode legality, error byte build).
package mtm_alu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CRC_W  = 4;

    // Legal opcodes
    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;

    // Frame type bit values
    localparam logic FT_DATA = 1'b0;
    localparam logic FT_CTL  = 1'b1;

    // Error byte bit positions
    localparam int unsigned ERR_MARK    = 7;
    localparam int unsigned ERR_CRC_HI  = 6;
    localparam int unsigned ERR_CRC_LO  = 5;
    localparam int unsigned ERR_OP_HI   = 4;
    localparam int unsigned ERR_OP_LO   = 3;
    localparam int unsigned ERR_DATA_HI = 2;
    localparam int unsigned ERR_DATA_LO = 1;
    localparam int unsigned ERR_PAR     = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_STOP,
        ST_RESYNC,
        ST_CHECK
    } state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Error byte: marker, doubled flags, parity over the upper seven bits
    function automatic logic [BYTE_W-1:0] err_frame_build(input logic data_err,
                                                          input logic crc_err,
                                                          input logic op_err);
        logic [BYTE_W-1:0] f;
        f              = '0;
        f[ERR_MARK]    = 1'b1;
        f[ERR_CRC_HI]  = crc_err;
        f[ERR_CRC_LO]  = crc_err;
        f[ERR_OP_HI]   = op_err;
        f[ERR_OP_LO]   = op_err;
        f[ERR_DATA_HI] = data_err;
        f[ERR_DATA_LO] = data_err;
        f[ERR_PAR]     = ^f[BYTE_W-1:1];
        return f;
    endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Serial CRC-4 (x^4 + x + 1), MSB first, init 0.
// Ports: clk, rst (async active-low), clear (sync zero), enable (absorb bit_in),
//        bit_in (serial data bit), crc (running remainder).
module mtm_alu_crc4
    import mtm_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ bit_in;

    // Shift left; on feedback xor in the low taps (x + 1)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ {2'b00, fb, fb};
        end
    end

endmodule

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver for the MTM ALU: collects 2*NBYTES DATA frames and a
// CTL frame, checks framing, CRC-4 and opcode, then presents operands with a
// valid/ready handshake or emits a one-cycle error byte.
// Ports: clk, rst (async active-low), din (serial, idles high),
//        a_o/b_o/op_o + out_valid/out_ready (packet output handshake),
//        err_valid/err_frame (error report), overrun (good packet dropped).
module mtm_alu_frame_rx
    import mtm_alu_pkg::*;
#(
    parameter int unsigned NBYTES   = 4,
    parameter bit          CHECK_OP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    output logic [8*NBYTES-1:0]   a_o,
    output logic [8*NBYTES-1:0]   b_o,
    output logic [2:0]            op_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_valid,
    output logic [7:0]            err_frame,
    output logic                  overrun
);

    localparam int unsigned W      = 8 * NBYTES;
    localparam int unsigned FRAMES = 2 * NBYTES;
    localparam int unsigned CNT_W  = $clog2(FRAMES + 1);
    localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);

    state_t            state, state_nxt;
    logic              ftype, ftype_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  frame_cnt, frame_cnt_nxt;
    logic              data_err, data_err_nxt;
    logic [2*W-1:0]    opnd, opnd_nxt;
    logic [W-1:0]      a_nxt, b_nxt;
    logic [OP_W-1:0]   op_nxt;
    logic              out_valid_nxt, err_valid_nxt, overrun_nxt;
    logic [BYTE_W-1:0] err_frame_nxt;

    logic              crc_clear, crc_en, crc_bit;
    logic [CRC_W-1:0]  crc;
    logic              crc_err_c, op_err_c;

    // CRC covers every DATA payload bit, then OP (CTL bits 6:4), then a zero
    // pad fed in place of the first received CRC bit.
    assign crc_en  = (state == ST_PAYLOAD) &&
                     ((ftype == FT_DATA) || ((bit_cnt >= 3'd1) && (bit_cnt <= 3'd4)));
    assign crc_bit = ((ftype == FT_CTL) && (bit_cnt == 3'd4)) ? 1'b0 : din;

    mtm_alu_crc4 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    assign crc_err_c = (crc != shreg[CRC_W-1:0]);
    assign op_err_c  = CHECK_OP && !op_legal(shreg[6:4]);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ftype     <= FT_DATA;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_cnt <= '0;
            data_err  <= 1'b0;
            opnd      <= '0;
            a_o       <= '0;
            b_o       <= '0;
            op_o      <= '0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_frame <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ftype     <= ftype_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            frame_cnt <= frame_cnt_nxt;
            data_err  <= data_err_nxt;
            opnd      <= opnd_nxt;
            a_o       <= a_nxt;
            b_o       <= b_nxt;
            op_o      <= op_nxt;
            out_valid <= out_valid_nxt;
            err_valid <= err_valid_nxt;
            err_frame <= err_frame_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        ftype_nxt     = ftype;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        frame_cnt_nxt = frame_cnt;
        data_err_nxt  = data_err;
        opnd_nxt      = opnd;
        a_nxt         = a_o;
        b_nxt         = b_o;
        op_nxt        = op_o;
        out_valid_nxt = out_valid;
        err_valid_nxt = 1'b0;
        err_frame_nxt = err_frame;
        overrun_nxt   = 1'b0;
        crc_clear     = 1'b0;

        // Accepted packet drops valid; a good packet in CHECK may re-raise it
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (!din) state_nxt = ST_TYPE;
            end
            ST_TYPE: begin
                ftype_nxt   = din;
                bit_cnt_nxt = '0;
                state_nxt   = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                shreg_nxt   = {shreg[BYTE_W-2:0], din};
                bit_cnt_nxt = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (!din) begin
                    data_err_nxt = 1'b1;
                    state_nxt    = ST_RESYNC;
                end else if (ftype == FT_DATA) begin
                    state_nxt = ST_IDLE;
                    if (frame_cnt == FRAMES_C) begin
                        data_err_nxt = 1'b1;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                        opnd_nxt      = {opnd[2*W-BYTE_W-1:0], shreg};
                    end
                end else begin
                    state_nxt = ST_CHECK;
                    if ((frame_cnt != FRAMES_C) || shreg[BYTE_W-1]) data_err_nxt = 1'b1;
                end
            end
            ST_RESYNC: begin
                if (din) state_nxt = ST_IDLE;
            end
            ST_CHECK: begin
                state_nxt     = ST_IDLE;
                frame_cnt_nxt = '0;
                data_err_nxt  = 1'b0;
                crc_clear     = 1'b1;
                if (data_err || crc_err_c || op_err_c) begin
                    // Framing errors mask CRC/opcode flags
                    err_valid_nxt = 1'b1;
                    err_frame_nxt = err_frame_build(data_err,
                                                    !data_err && crc_err_c,
                                                    !data_err && op_err_c);
                end else if (out_valid && !out_ready) begin
                    overrun_nxt = 1'b1;
                end else begin
                    a_nxt         = opnd[W-1:0];
                    b_nxt         = opnd[2*W-1:W];
                    op_nxt        = shreg[6:4];
                    out_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Directed self-checking bench for mtm_alu_frame_rx.
// dut: NBYTES=4, CHECK_OP=1; dut_nc: NBYTES=4, CHECK_OP=0 (shares din/rst);
// dut1: NBYTES=1 on its own line and reset.
module tb_mtm_alu_frame_rx;

    logic        clk;
    logic        rst, rst1;
    logic        din, din1;
    logic        out_ready, nc_ready, rdy1;

    logic [31:0] a_o, b_o, nc_a, nc_b;
    logic [2:0]  op_o, nc_op, op1;
    logic        out_valid, err_valid, overrun;
    logic        nc_valid, nc_err_valid, nc_overrun;
    logic [7:0]  err_frame, nc_err_frame, ef1;
    logic [7:0]  a1, b1;
    logic        ov1, ev1, or1;

    int n_cmp, n_fail;
    int ovr_cnt, ev1_cnt;

    mtm_alu_frame_rx #(.NBYTES(4), .CHECK_OP(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .a_o(a_o), .b_o(b_o), .op_o(op_o),
        .out_valid(out_valid), .out_ready(out_ready), .err_valid(err_valid),
        .err_frame(err_frame), .overrun(overrun)
    );

    mtm_alu_frame_rx #(.NBYTES(4), .CHECK_OP(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .din(din), .a_o(nc_a), .b_o(nc_b), .op_o(nc_op),
        .out_valid(nc_valid), .out_ready(nc_ready), .err_valid(nc_err_valid),
        .err_frame(nc_err_frame), .overrun(nc_overrun)
    );

    mtm_alu_frame_rx #(.NBYTES(1), .CHECK_OP(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .din(din1), .a_o(a1), .b_o(b1), .op_o(op1),
        .out_valid(ov1), .out_ready(rdy1), .err_valid(ev1),
        .err_frame(ef1), .overrun(or1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (ev1) ev1_cnt++;
    end

    task automatic send_bit(input bit tgt, input logic b);
        @(negedge clk);
        if (tgt) din1 = b;
        else     din  = b;
    endtask

    task automatic send_frame(input bit tgt, input logic t, input logic [7:0] p, input logic stopb);
        send_bit(tgt, 1'b0);
        send_bit(tgt, t);
        for (int i = 7; i >= 0; i--) send_bit(tgt, p[i]);
        send_bit(tgt, stopb);
    endtask

    task automatic send_pkt(input bit tgt, input int nb, input logic [31:0] b,
                            input logic [31:0] a, input logic [7:0] ctl);
        for (int i = nb - 1; i >= 0; i--) send_frame(tgt, 1'b0, b[8*i +: 8], 1'b1);
        for (int i = nb - 1; i >= 0; i--) send_frame(tgt, 1'b0, a[8*i +: 8], 1'b1);
        send_frame(tgt, 1'b1, ctl, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (a_o !== 32'h0)       begin n_fail++; $display("FAIL rst_a: got %h want 0", a_o); end
        n_cmp++; if (b_o !== 32'h0)       begin n_fail++; $display("FAIL rst_b: got %h want 0", b_o); end
        n_cmp++; if (op_o !== 3'b000)     begin n_fail++; $display("FAIL rst_op: got %b want 000", op_o); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (err_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_err_valid: got %b want 0", err_valid); end
        n_cmp++; if (err_frame !== 8'h00) begin n_fail++; $display("FAIL rst_err_frame: got %h want 00", err_frame); end
        n_cmp++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        rst  = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good();
        out_ready = 1'b1;
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h0B);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_latency: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1)    begin n_fail++; $display("FAIL good_valid: got %b want 1", out_valid); end
        n_cmp++; if (a_o !== 32'h1)         begin n_fail++; $display("FAIL good_a: got %h want 00000001", a_o); end
        n_cmp++; if (b_o !== 32'h2)         begin n_fail++; $display("FAIL good_b: got %h want 00000002", b_o); end
        n_cmp++; if (op_o !== 3'b000)       begin n_fail++; $display("FAIL good_op: got %b want 000", op_o); end
        n_cmp++; if (err_valid !== 1'b0)    begin n_fail++; $display("FAIL good_no_err: got %b want 0", err_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL good_accept: got %b want 0", out_valid); end
    endtask

    task automatic test_crc_err();
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h0A);
        @(negedge clk);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL crc_early: got %b want 0", err_valid); end
        @(negedge clk);
        n_cmp++; if (err_valid !== 1'b1)     begin n_fail++; $display("FAIL crc_err_valid: got %b want 1", err_valid); end
        n_cmp++; if (err_frame !== 8'hE1)    begin n_fail++; $display("FAIL crc_err_frame: got %h want E1", err_frame); end
        n_cmp++; if (nc_err_frame !== 8'hE1) begin n_fail++; $display("FAIL crc_nc_err_frame: got %h want E1", nc_err_frame); end
        n_cmp++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL crc_no_valid: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL crc_pulse_len: got %b want 0", err_valid); end
    endtask

    task automatic test_short();
        for (int i = 0; i < 3; i++) send_frame(1'b0, 1'b0, 8'h00, 1'b1);
        send_frame(1'b0, 1'b1, 8'h0B, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++; if (err_valid !== 1'b1)  begin n_fail++; $display("FAIL short_err_valid: got %b want 1", err_valid); end
        n_cmp++; if (err_frame !== 8'h87) begin n_fail++; $display("FAIL short_err_frame: got %h want 87", err_frame); end
        @(negedge clk);
    endtask

    task automatic test_stop_err();
        logic [63:0] data;
        data = 64'h00000002_00000001;
        for (int i = 7; i >= 0; i--) begin
            send_frame(1'b0, 1'b0, data[8*i +: 8], (i == 5) ? 1'b0 : 1'b1);
            if (i == 5) send_bit(1'b0, 1'b1);
        end
        send_frame(1'b0, 1'b1, 8'h0B, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++; if (err_valid !== 1'b1)  begin n_fail++; $display("FAIL stop_err_valid: got %b want 1", err_valid); end
        n_cmp++; if (err_frame !== 8'h87) begin n_fail++; $display("FAIL stop_err_frame: got %h want 87", err_frame); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL stop_no_valid: got %b want 0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_op_err();
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h7A);
        repeat (2) @(negedge clk);
        n_cmp++; if (err_valid !== 1'b1)    begin n_fail++; $display("FAIL op_err_valid: got %b want 1", err_valid); end
        n_cmp++; if (err_frame !== 8'h99)   begin n_fail++; $display("FAIL op_err_frame: got %h want 99", err_frame); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL op_no_valid: got %b want 0", out_valid); end
        n_cmp++; if (nc_valid !== 1'b1)     begin n_fail++; $display("FAIL op_nc_valid: got %b want 1", nc_valid); end
        n_cmp++; if (nc_op !== 3'b111)      begin n_fail++; $display("FAIL op_nc_op: got %b want 111", nc_op); end
        n_cmp++; if (nc_a !== 32'h1)        begin n_fail++; $display("FAIL op_nc_a: got %h want 00000001", nc_a); end
        n_cmp++; if (nc_b !== 32'h2)        begin n_fail++; $display("FAIL op_nc_b: got %h want 00000002", nc_b); end
        n_cmp++; if (nc_err_valid !== 1'b0) begin n_fail++; $display("FAIL op_nc_no_err: got %b want 0", nc_err_valid); end
        n_cmp++; if (nc_overrun !== 1'b0)   begin n_fail++; $display("FAIL op_nc_overrun: got %b want 0", nc_overrun); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base;
        out_ready = 1'b0;
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h0B);
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", out_valid); end
        base = ovr_cnt;
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h1D);
        repeat (2) @(negedge clk);
        n_cmp++; if (overrun !== 1'b1)   begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_held_valid: got %b want 1", out_valid); end
        n_cmp++; if (op_o !== 3'b000)    begin n_fail++; $display("FAIL b2b_held_op: got %b want 000", op_o); end
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL b2b_overrun_len: got %b want 0", overrun); end
        // Third packet lands in the same cycle the held one is accepted
        send_pkt(1'b0, 4, 32'h2, 32'h1, 8'h1D);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_reload_valid: got %b want 1", out_valid); end
        n_cmp++; if (op_o !== 3'b001)    begin n_fail++; $display("FAIL b2b_reload_op: got %b want 001", op_o); end
        n_cmp++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL b2b_delivered: got %b want 0", out_valid); end
        n_cmp++; if (ovr_cnt - base !== 1)  begin n_fail++; $display("FAIL b2b_overrun_count: got %0d want 1", ovr_cnt - base); end
    endtask

    task automatic test_nbytes1();
        int base;
        rdy1 = 1'b1;
        send_pkt(1'b1, 1, 32'h5A, 32'h3C, 8'h4A);
        repeat (2) @(negedge clk);
        n_cmp++; if (ov1 !== 1'b1)   begin n_fail++; $display("FAIL n1_valid: got %b want 1", ov1); end
        n_cmp++; if (a1 !== 8'h3C)   begin n_fail++; $display("FAIL n1_a: got %h want 3C", a1); end
        n_cmp++; if (b1 !== 8'h5A)   begin n_fail++; $display("FAIL n1_b: got %h want 5A", b1); end
        n_cmp++; if (op1 !== 3'b100) begin n_fail++; $display("FAIL n1_op: got %b want 100", op1); end
        // Partial frame, then reset mid-frame
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        #3 rst1 = 1'b0;
        #1;
        n_cmp++; if (a1 !== 8'h00)   begin n_fail++; $display("FAIL n1_rst_a: got %h want 00", a1); end
        n_cmp++; if (b1 !== 8'h00)   begin n_fail++; $display("FAIL n1_rst_b: got %h want 00", b1); end
        n_cmp++; if (op1 !== 3'b000) begin n_fail++; $display("FAIL n1_rst_op: got %b want 000", op1); end
        n_cmp++; if (ov1 !== 1'b0)   begin n_fail++; $display("FAIL n1_rst_valid: got %b want 0", ov1); end
        n_cmp++; if (ef1 !== 8'h00)  begin n_fail++; $display("FAIL n1_rst_err_frame: got %h want 00", ef1); end
        n_cmp++; if (or1 !== 1'b0)   begin n_fail++; $display("FAIL n1_rst_overrun: got %b want 0", or1); end
        din1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        base = ev1_cnt;
        repeat (3) @(negedge clk);
        send_pkt(1'b1, 1, 32'h00, 32'h01, 8'h13);
        repeat (2) @(negedge clk);
        n_cmp++; if (ov1 !== 1'b1)   begin n_fail++; $display("FAIL n1_post_valid: got %b want 1", ov1); end
        n_cmp++; if (a1 !== 8'h01)   begin n_fail++; $display("FAIL n1_post_a: got %h want 01", a1); end
        n_cmp++; if (b1 !== 8'h00)   begin n_fail++; $display("FAIL n1_post_b: got %h want 00", b1); end
        n_cmp++; if (op1 !== 3'b001) begin n_fail++; $display("FAIL n1_post_op: got %b want 001", op1); end
        n_cmp++; if (ev1_cnt - base !== 0) begin n_fail++; $display("FAIL n1_no_err_after_rst: got %0d want 0", ev1_cnt - base); end
        @(negedge clk);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        ovr_cnt   = 0;
        ev1_cnt   = 0;
        rst       = 1'b1;
        rst1      = 1'b1;
        din       = 1'b1;
        din1      = 1'b1;
        out_ready = 1'b1;
        nc_ready  = 1'b1;
        rdy1      = 1'b1;
        #2;
        rst  = 1'b0;
        rst1 = 1'b0;

        test_reset();
        test_good();
        test_crc_err();
        test_short();
        test_stop_err();
        test_op_err();
        test_back_to_back();
        test_nbytes1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
